// File: rtl/vcpu32_pkg.sv
// vcpu32_pkg: shared core constants, arbiter state/owner types and cache line geometry.
package vcpu32_pkg;
    localparam int WORD_LENGTH  = 32;
    localparam int LINE_WORDS   = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int WORD_BYTES   = WORD_LENGTH / 8;
    localparam int LINE_BYTES   = LINE_WORDS * WORD_BYTES;
    localparam int LINE_OFS     = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {IDLE, BURST_I, BURST_D, DONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_burst_counter.sv
// mem_burst_counter: beat counter for line bursts; wraps to 0 after the last beat.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : force count to 0
//   inc_i    : advance one beat
//   cnt_o    : current beat index
//   last_o   : current beat is the final one of the line
module mem_burst_counter #(
    parameter int BEATS = 4,
    localparam int CW = $clog2(BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = cnt_q == CW'(BEATS - 1);
    assign cnt_o  = cnt_q;

    always_comb cnt_d = clr_i ? '0 : inc_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;

    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_if_arbiter.sv
// mem_if_arbiter: shares one memory port between I-cache and D-cache line bursts.
//   Optional macro MEM_ARB_FAIR_EN: D-side starvation counter forces a D grant.
//   I side : iReq/iAdr in, iDone out
//   D side : dReq/dWrite/dAdr/dWData in, dWNext/dDone out
//   Reads  : rdData with iRdValid/dRdValid, one clock after memRdy
//   Memory : memReq/memWrite/memAdr/memWData out, memRdy/memRData in
module mem_if_arbiter #(
    parameter int WORD_LENGTH  = vcpu32_pkg::WORD_LENGTH,
    parameter int LINE_WORDS   = vcpu32_pkg::LINE_WORDS,
    parameter int STARVE_LIMIT = vcpu32_pkg::STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iReq,
    input  logic [WORD_LENGTH-1:0] iAdr,
    output logic                   iDone,
    input  logic                   dReq,
    input  logic                   dWrite,
    input  logic [WORD_LENGTH-1:0] dAdr,
    input  logic [WORD_LENGTH-1:0] dWData,
    output logic                   dWNext,
    output logic                   dDone,
    output logic [WORD_LENGTH-1:0] rdData,
    output logic                   iRdValid,
    output logic                   dRdValid,
    output logic                   memReq,
    output logic                   memWrite,
    output logic [WORD_LENGTH-1:0] memAdr,
    output logic [WORD_LENGTH-1:0] memWData,
    input  logic                   memRdy,
    input  logic [WORD_LENGTH-1:0] memRData
);
    import vcpu32_pkg::*;

    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFS = CW + 2;

    if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("mem_if_arbiter: LINE_WORDS must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    arb_state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic write_q, write_d;
    logic [WORD_LENGTH-1:0] base_q, base_d, rd_data_q, sel_adr;
    logic i_vld_q, d_vld_q;
    logic [CW-1:0] cnt;
    logic last, busy, xfer, rd_xfer, pick_d, force_d, unused_low;

    assign busy    = state_q == BURST_I || state_q == BURST_D;
    assign xfer    = busy && memRdy;
    assign rd_xfer = xfer && !write_q;
    assign pick_d  = dReq && (!iReq || force_d);
    assign sel_adr = pick_d ? dAdr : iAdr;
    // Offset bits inside the line are dropped: bursts always start at beat 0.
    assign unused_low = ^sel_adr[OFS-1:0];

    mem_burst_counter #(.BEATS(LINE_WORDS)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == IDLE),
        .inc_i (xfer),
        .cnt_o (cnt),
        .last_o(last)
    );

`ifdef MEM_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    logic d_owns;
    // D stays owner through its DONE cycle, where dReq is still legitimately high.
    assign d_owns  = state_q == BURST_D || (state_q == DONE && owner_q == OWN_D);
    assign force_d = starve_q == SW'(STARVE_LIMIT);
    always_comb starve_d = (state_q == IDLE && pick_d) ? '0 :
                           (dReq && !d_owns && !force_d) ? starve_q + 1'b1 : starve_q;
    always_ff @(posedge clk) starve_q <= rst ? '0 : starve_d;
`else
    assign force_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        base_d  = base_q;
        case (state_q)
            IDLE: if (iReq || dReq) begin
                state_d = pick_d ? BURST_D : BURST_I;
                owner_d = pick_d ? OWN_D : OWN_I;
                write_d = pick_d && dWrite;
                base_d  = {sel_adr[WORD_LENGTH-1:OFS], {OFS{1'b0}}};
            end
            BURST_I, BURST_D: state_d = (xfer && last) ? DONE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            write_q   <= 1'b0;
            base_q    <= '0;
            rd_data_q <= '0;
            i_vld_q   <= 1'b0;
            d_vld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            base_q    <= base_d;
            rd_data_q <= rd_xfer ? memRData : rd_data_q;
            i_vld_q   <= rd_xfer && state_q == BURST_I;
            d_vld_q   <= rd_xfer && state_q == BURST_D;
        end
    end

    assign memReq   = busy;
    assign memWrite = busy && write_q;
    // Base has its offset bits clear, so the beat index concatenates in without an adder.
    assign memAdr   = busy ? {base_q[WORD_LENGTH-1:OFS], cnt, 2'b00} : '0;
    assign memWData = dWData;
    assign dWNext   = memWrite && memRdy;
    assign rdData   = rd_data_q;
    assign iRdValid = i_vld_q;
    assign dRdValid = d_vld_q;
    assign iDone    = state_q == DONE && owner_q == OWN_I;
    assign dDone    = state_q == DONE && owner_q == OWN_D;
endmodule

// File: tb/tb_mem_if_arbiter.sv
// tb_mem_if_arbiter: randomized scoreboard bench for the I/D line-burst memory arbiter.
module tb_mem_if_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic iReq = 1'b0, dReq = 1'b0, dWrite = 1'b0, memRdy = 1'b1;
    logic [31:0] iAdr = '0, dAdr = '0, memRData = '0, dWData, dbase = '0;
    logic iDone, dWNext, dDone, iRdValid, dRdValid, memReq, memWrite;
    logic [31:0] rdData, memAdr, memWData;
    int nchk = 0, nfail = 0, cyc = 0, widx = 0, wstart = 0, mode = 0;
    int last_iv = 0, last_dv = 0, last_w = 0, i_pend = 0;
    bit mon_en = 1'b1;
    logic [31:0] iq[$], dq[$], wa[$], wd[$];
    bit dk[$];

    always #5 clk = ~clk;

    mem_if_arbiter dut (
        .clk(clk), .rst(rst), .iReq(iReq), .iAdr(iAdr), .iDone(iDone),
        .dReq(dReq), .dWrite(dWrite), .dAdr(dAdr), .dWData(dWData), .dWNext(dWNext), .dDone(dDone),
        .rdData(rdData), .iRdValid(iRdValid), .dRdValid(dRdValid),
        .memReq(memReq), .memWrite(memWrite), .memAdr(memAdr), .memWData(memWData),
        .memRdy(memRdy), .memRData(memRData)
    );

    function automatic logic [31:0] rfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] gfun(input logic [31:0] b, input int k);
        return (b ^ 32'hA5C3_0F1E) + 32'(k) * 32'h0101_0107;
    endfunction

    assign dWData = gfun(dbase, widx - wstart);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory side: ready pattern per mode, read data is a pure function of the word address.
    initial begin
        bit wn, tog;
        wn = 1'b0;
        tog = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wn) widx++;
            tog = ~tog;
            memRdy = mode == 0 ? 1'b1 : mode == 2 ? tog : ($urandom_range(3) != 0);
            memRData = rfun(memAdr);
            @(negedge clk);
            wn = dWNext;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents data, a write beat or a done pulse.
    initial begin
        bit stall_prev;
        logic [31:0] stall_adr;
        bit k;
        stall_prev = 1'b0;
        stall_adr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (iRdValid) begin
                    if (iq.size() == 0) chk("i_rd_unexpected", iRdValid, 0);
                    else begin chk("i_rd_data", rdData, iq.pop_front()); last_iv = cyc; end
                end
                if (dRdValid) begin
                    if (dq.size() == 0) chk("d_rd_unexpected", dRdValid, 0);
                    else begin chk("d_rd_data", rdData, dq.pop_front()); last_dv = cyc; end
                end
                if (memReq && memRdy && memWrite) begin
                    chk("d_wnext_on_write", dWNext, 1);
                    if (wa.size() == 0) chk("d_wr_unexpected", memWrite, 0);
                    else begin
                        chk("d_wr_adr", memAdr, wa.pop_front());
                        chk("d_wr_data", memWData, wd.pop_front());
                        last_w = cyc;
                    end
                end else if (memReq && memRdy) chk("d_wnext_on_read", dWNext, 0);
                if (stall_prev && memReq) chk("stall_adr_hold", memAdr, stall_adr);
                stall_prev = memReq && !memRdy;
                stall_adr = memAdr;
                if (iDone) begin
                    if (i_pend == 0) chk("i_done_unexpected", iDone, 0);
                    else begin
                        i_pend--;
                        chk("i_done_words_left", iq.size(), 0);
                        chk("i_done_latency", cyc - last_iv, 0);
                    end
                end
                if (dDone) begin
                    if (dk.size() == 0) chk("d_done_unexpected", dDone, 0);
                    else begin
                        k = dk.pop_front();
                        chk("d_done_words_left", dq.size() + wa.size(), 0);
                        chk("d_done_latency", cyc - (k ? last_w : last_dv), k ? 1 : 0);
                    end
                end
            end else stall_prev = 1'b0;
        end
    end

    task automatic i_req(input logic [31:0] a, input bit drop);
        logic [31:0] b;
        int n;
        b = {a[31:4], 4'h0};
        for (int k = 0; k < 4; k++) iq.push_back(rfun(b + 32'(4 * k)));
        i_pend++;
        @(posedge clk);
        #1;
        iReq = 1'b1;
        iAdr = a;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (iDone) break;
            if (drop && iRdValid && iReq) begin
                @(posedge clk);
                #1;
                iReq = 1'b0;
            end
        end
        chk("i_done_within_bound", n < 300, 1);
        @(posedge clk);
        #1;
        iReq = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] a, input bit wr);
        logic [31:0] b;
        int n;
        b = {a[31:4], 4'h0};
        for (int k = 0; k < 4; k++) begin
            if (wr) begin wa.push_back(b + 32'(4 * k)); wd.push_back(gfun(b, k)); end
            else dq.push_back(rfun(b + 32'(4 * k)));
        end
        dk.push_back(wr);
        @(posedge clk);
        #1;
        dbase = b;
        wstart = widx;
        dWrite = wr;
        dAdr = a;
        dReq = 1'b1;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (dDone) break;
        end
        chk("d_done_within_bound", n < 300, 1);
        @(posedge clk);
        #1;
        dReq = 1'b0;
        dWrite = 1'($urandom_range(1));
    endtask

    initial begin
        int n, g, ni, nd;
        repeat (3) @(negedge clk);
        chk("rst_memReq", memReq, 0);
        chk("rst_memWrite", memWrite, 0);
        chk("rst_memAdr", memAdr, 0);
        chk("rst_iDone", iDone, 0);
        chk("rst_dDone", dDone, 0);
        chk("rst_iRdValid", iRdValid, 0);
        chk("rst_dRdValid", dRdValid, 0);
        chk("rst_dWNext", dWNext, 0);
        chk("rst_rdData", rdData, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        mode = 0;
        i_req(32'h0000_1004, 1'b0);

        fork
            i_req(32'h0000_4008, 1'b0);
            d_req(32'h0000_5004, 1'b1);
            begin
                for (n = 0; n < 100; n++) begin @(negedge clk); if (memReq) break; end
                chk("tie_first_adr", memAdr, 32'h0000_4000);
                chk("tie_first_is_read", memWrite, 0);
                for (n = 0; n < 100; n++) begin @(negedge clk); if (iDone) break; end
                for (g = 1; g < 100; g++) begin @(negedge clk); if (memReq) break; end
                chk("tie_d_grant_gap", g, 2);
            end
        join

        mode = 2;
        d_req(32'h0000_2000, 1'b1);
        mode = 0;
        i_req(32'h0000_1A0C, 1'b1);
        mode = 1;
        d_req(32'h0000_8014, 1'b0);

        mode = 0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        dAdr = 32'h0000_3004;
        dWrite = 1'b0;
        dReq = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (memReq && memAdr == 32'h0000_3004) break; end
        chk("rst_test_beat1_seen", n < 50, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dReq = 1'b0;
        @(negedge clk);
        chk("rst_test_beat2_adr", memAdr, 32'h0000_3008);
        @(negedge clk);
        chk("rst_abort_memReq", memReq, 0);
        chk("rst_abort_dDone", dDone, 0);
        chk("rst_abort_dRdValid", dRdValid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge clk); chk("rst_abort_no_late_dDone", dDone, 0); end
        mon_en = 1'b1;
        d_req(32'h0000_300C, 1'b0);

        mon_en = 1'b0;
        @(posedge clk);
        #1;
        iReq = 1'b1;
        iAdr = 32'h0000_6000;
        dReq = 1'b1;
        dWrite = 1'b0;
        dAdr = 32'h0000_7000;
        ni = 0;
        nd = 0;
        for (n = 0; n < 120 && nd == 0; n++) begin
            @(negedge clk);
            if (iDone) ni++;
            if (dDone) nd++;
        end
`ifdef MEM_ARB_FAIR_EN
        chk("fair_d_granted", nd, 1);
        chk("fair_i_bursts_before_d", ni, 2);
`else
        chk("strict_d_starved", nd, 0);
        chk("strict_i_bursts", ni > 10, 1);
`endif
        @(posedge clk);
        #1;
        iReq = 1'b0;
        dReq = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        mode = 1;
        fork
            for (int k = 0; k < 12; k++) begin
                repeat ($urandom_range(4)) @(posedge clk);
                i_req($urandom, 1'($urandom_range(1)));
            end
            for (int k = 0; k < 12; k++) begin
                repeat ($urandom_range(6)) @(posedge clk);
                d_req($urandom, 1'($urandom_range(1)));
            end
        join
        repeat (5) @(negedge clk);
        chk("end_i_queue_empty", iq.size(), 0);
        chk("end_d_queue_empty", dq.size() + wa.size(), 0);
        chk("end_pending_done", i_pend + dk.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
